udp_rx_parser: RTL and testbench

UDP_RX_PARSER -- requirements
Module: udp_rx_parser

---
 rtl/udp_rx_parser.sv | 215 +++++++++++++++++++++
 tb/tb_udp_rx_parser.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_parser.sv
// Receive-side Ethernet/IPv4/UDP filter: strips headers and streams the payload of frames addressed to us.
// Optional FCS verification is compiled in with `define UDP_RX_FCS_CHECK_EN.
module udp_rx_parser #(
    parameter logic [47:0] LOCAL_MAC  = 48'h000A35000001,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8010A,
    parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_err,
    output logic [7:0]  udp_rx_data,
    output logic        udp_rx_valid,
    output logic        udp_rx_last,
    output logic        frame_ok,
    output logic        frame_drop,
    output logic [15:0] pkt_count
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAILER, DROP
    } state_t;

    state_t      state;
    logic [4:0]  byte_cnt;
    logic [15:0] pay_cnt;
    logic [7:0]  len_hi;
    logic        mac_uni, mac_bc;
    logic        armed;
    logic        hdr_bad, uni_n, bc_n;
    logic        fcs_pass;

    function automatic logic [7:0] mac_byte(input logic [2:0] i);
        logic [47:0] s;
        s = LOCAL_MAC << (8 * i);
        return s[47:40];
    endfunction

    function automatic logic [7:0] ip_byte(input logic [1:0] i);
        logic [31:0] s;
        s = LOCAL_IP << (8 * i);
        return s[31:24];
    endfunction

    // Per-byte header field checks; a mismatch diverts the frame to DROP on that byte.
    always_comb begin
        hdr_bad = 1'b0;
        uni_n   = mac_uni;
        bc_n    = mac_bc;
        case (state)
            ETH_HDR: begin
                if (byte_cnt < 5'd6) begin
                    uni_n = mac_uni && (rx_data == mac_byte(byte_cnt[2:0]));
                    bc_n  = mac_bc && (rx_data == 8'hFF);
                    if (byte_cnt == 5'd5 && !uni_n && !bc_n) hdr_bad = 1'b1;
                end
                if (byte_cnt == 5'd12 && rx_data != 8'h08) hdr_bad = 1'b1;
                if (byte_cnt == 5'd13 && rx_data != 8'h00) hdr_bad = 1'b1;
            end
            IP_HDR: begin
                if (byte_cnt == 5'd0 && rx_data != 8'h45) hdr_bad = 1'b1;
                if (byte_cnt == 5'd9 && rx_data != 8'h11) hdr_bad = 1'b1;
                if (byte_cnt >= 5'd16 && rx_data != ip_byte(byte_cnt[1:0])) hdr_bad = 1'b1;
            end
            UDP_HDR: begin
                if (byte_cnt == 5'd2 && rx_data != LOCAL_PORT[15:8]) hdr_bad = 1'b1;
                if (byte_cnt == 5'd3 && rx_data != LOCAL_PORT[7:0]) hdr_bad = 1'b1;
                if (byte_cnt == 5'd5 && {len_hi, rx_data} < 16'd8) hdr_bad = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef UDP_RX_FCS_CHECK_EN
    // Reflected register 0xDEBB20E3 is the good-frame residue; compared here in MSB-first bit order.
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;
    logic [31:0] crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            crc <= 32'd0;
        end else if (state == PREAMBLE && rx_valid && rx_data == 8'hD5) begin
            crc <= 32'hFFFFFFFF;
        end else if (rx_valid && state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAILER}) begin
            crc <= crc_byte(crc, rx_data);
        end
    end

    assign fcs_pass = ({<<{crc}} == RESIDUE);
`else
    assign fcs_pass = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            byte_cnt     <= 5'd0;
            pay_cnt      <= 16'd0;
            len_hi       <= 8'd0;
            mac_uni      <= 1'b0;
            mac_bc       <= 1'b0;
            armed        <= 1'b0;
            udp_rx_data  <= 8'd0;
            udp_rx_valid <= 1'b0;
            udp_rx_last  <= 1'b0;
            frame_ok     <= 1'b0;
            frame_drop   <= 1'b0;
            pkt_count    <= 16'd0;
        end else begin
            udp_rx_valid <= 1'b0;
            udp_rx_last  <= 1'b0;
            frame_ok     <= 1'b0;
            frame_drop   <= 1'b0;
            // A frame already in flight when reset lifts is skipped until the line goes idle.
            if (!rx_valid) armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (rx_valid && armed) begin
                        if (rx_data == 8'h55) begin
                            state <= PREAMBLE;
                        end else begin
                            state      <= DROP;
                            frame_drop <= 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (!rx_valid) state <= IDLE;
                end
                TRAILER: begin
                    if (!rx_valid) begin
                        state <= IDLE;
                        if (fcs_pass) begin
                            frame_ok  <= 1'b1;
                            pkt_count <= pkt_count + 16'd1;
                        end else begin
                            frame_drop <= 1'b1;
                        end
                    end else if (rx_err) begin
                        state      <= DROP;
                        frame_drop <= 1'b1;
                    end
                end
                default: begin
                    if (!rx_valid) begin
                        state      <= IDLE;
                        frame_drop <= 1'b1;
                    end else if (rx_err || hdr_bad) begin
                        state      <= DROP;
                        frame_drop <= 1'b1;
                    end else begin
                        case (state)
                            PREAMBLE: begin
                                if (rx_data == 8'hD5) begin
                                    state    <= ETH_HDR;
                                    byte_cnt <= 5'd0;
                                    mac_uni  <= 1'b1;
                                    mac_bc   <= 1'b1;
                                end else if (rx_data != 8'h55) begin
                                    state      <= DROP;
                                    frame_drop <= 1'b1;
                                end
                            end
                            ETH_HDR: begin
                                mac_uni  <= uni_n;
                                mac_bc   <= bc_n;
                                byte_cnt <= byte_cnt + 5'd1;
                                if (byte_cnt == 5'd13) begin
                                    state    <= IP_HDR;
                                    byte_cnt <= 5'd0;
                                end
                            end
                            IP_HDR: begin
                                byte_cnt <= byte_cnt + 5'd1;
                                if (byte_cnt == 5'd19) begin
                                    state    <= UDP_HDR;
                                    byte_cnt <= 5'd0;
                                end
                            end
                            UDP_HDR: begin
                                byte_cnt <= byte_cnt + 5'd1;
                                if (byte_cnt == 5'd4) len_hi <= rx_data;
                                if (byte_cnt == 5'd5) pay_cnt <= {len_hi, rx_data} - 16'd8;
                                if (byte_cnt == 5'd7) begin
                                    byte_cnt <= 5'd0;
                                    state    <= (pay_cnt == 16'd0) ? TRAILER : PAYLOAD;
                                end
                            end
                            PAYLOAD: begin
                                udp_rx_valid <= 1'b1;
                                udp_rx_data  <= rx_data;
                                pay_cnt      <= pay_cnt - 16'd1;
                                if (pay_cnt == 16'd1) begin
                                    udp_rx_last <= 1'b1;
                                    state       <= TRAILER;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Scoreboard bench for udp_rx_parser: frames built with a real FCS, expected beats/verdicts queued at drive time.
module tb_udp_rx_parser;
    localparam logic [47:0] LMAC = 48'h000A35000001;
    localparam logic [31:0] LIP  = 32'hC0A8010A;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_err = 1'b0;
    logic [7:0]  udp_rx_data;
    logic        udp_rx_valid, udp_rx_last, frame_ok, frame_drop;
    logic [15:0] pkt_count;

    always #4 clk = ~clk;

    udp_rx_parser dut (
        .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .udp_rx_data(udp_rx_data), .udp_rx_valid(udp_rx_valid), .udp_rx_last(udp_rx_last),
        .frame_ok(frame_ok), .frame_drop(frame_drop), .pkt_count(pkt_count)
    );

    int          total = 0, bad = 0;
    logic [8:0]  beat_q[$];
    logic [16:0] verdict_q[$];
    logic [7:0]  fb[$], pl[$];
    logic [15:0] mdl_cnt = 16'd0;
    logic [7:0]  last_in = 8'd0;
    logic [8:0]  bq_v;
    logic [16:0] vq_v;

    logic [47:0] f_mac;
    logic [15:0] f_etype, f_port, f_len;
    logic [7:0]  f_ver, f_proto;
    logic [31:0] f_ip;
    int          f_pad;
    bit          f_fcs_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) last_in <= rx_data;

    always @(negedge clk) begin
        if (udp_rx_valid) begin
            if (beat_q.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
            else begin
                bq_v = beat_q.pop_front();
                chk("beat_data", {24'd0, udp_rx_data}, {24'd0, bq_v[7:0]});
                chk("beat_last", {31'd0, udp_rx_last}, {31'd0, bq_v[8]});
                chk("beat_latency", {24'd0, udp_rx_data}, {24'd0, last_in});
            end
        end else if (udp_rx_last) begin
            chk("last_without_valid", 32'd1, 32'd0);
        end
        if (frame_ok || frame_drop) begin
            chk("ok_drop_exclusive", {31'd0, frame_ok & frame_drop}, 32'd0);
            if (verdict_q.size() == 0) chk("verdict_unexpected", 32'd1, 32'd0);
            else begin
                vq_v = verdict_q.pop_front();
                chk("verdict_ok", {31'd0, frame_ok}, {31'd0, vq_v[16]});
                chk("pkt_count", {16'd0, pkt_count}, {16'd0, vq_v[15:0]});
            end
        end
    end

    task automatic defaults();
        f_mac = LMAC; f_etype = 16'h0800; f_ver = 8'h45; f_proto = 8'h11;
        f_ip = LIP; f_port = 16'd5000; f_pad = 0; f_fcs_bad = 1'b0;
        pl.delete();
        pl.push_back(8'hDE); pl.push_back(8'hAD); pl.push_back(8'hBE); pl.push_back(8'hEF);
        f_len = 16'd12;
    endtask

    task automatic build();
        logic [7:0]  body[$];
        logic [31:0] c;
        logic [15:0] tot;
        tot = 16'd20 + f_len;
        for (int i = 5; i >= 0; i--) body.push_back(f_mac[8*i +: 8]);
        body.push_back(8'h02); repeat (4) body.push_back(8'h00); body.push_back(8'h02);
        body.push_back(f_etype[15:8]); body.push_back(f_etype[7:0]);
        body.push_back(f_ver); body.push_back(8'h00); body.push_back(tot[15:8]); body.push_back(tot[7:0]);
        body.push_back(8'h00); body.push_back(8'h00); body.push_back(8'h40); body.push_back(8'h00);
        body.push_back(8'h40); body.push_back(f_proto); body.push_back(8'h00); body.push_back(8'h00);
        body.push_back(8'hC0); body.push_back(8'hA8); body.push_back(8'h01); body.push_back(8'h01);
        for (int i = 3; i >= 0; i--) body.push_back(f_ip[8*i +: 8]);
        body.push_back(8'h04); body.push_back(8'hD2);
        body.push_back(f_port[15:8]); body.push_back(f_port[7:0]);
        body.push_back(f_len[15:8]); body.push_back(f_len[7:0]);
        body.push_back(8'h00); body.push_back(8'h00);
        foreach (pl[i]) body.push_back(pl[i]);
        repeat (f_pad) body.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (body[i]) begin
            c = c ^ {24'd0, body[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        fb.delete();
        repeat (7) fb.push_back(8'h55);
        fb.push_back(8'hD5);
        foreach (body[i]) fb.push_back(body[i]);
        for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
        if (f_fcs_bad) fb[fb.size()-1] = fb[fb.size()-1] ^ 8'h01;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic e);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b; rx_err = e;
    endtask

    // Drives the first n bytes of fb, then one idle cycle.
    task automatic send(input int n, input int err_idx);
        for (int i = 0; i < n; i++) drive_byte(fb[i], i == err_idx);
        @(negedge clk);
        rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    endtask

    task automatic exp_beats(input int n, input bit full);
        for (int i = 0; i < n; i++) beat_q.push_back({full && (i == pl.size() - 1), pl[i]});
    endtask

    task automatic exp_verdict(input bit ok);
        if (ok) mdl_cnt = mdl_cnt + 16'd1;
        verdict_q.push_back({ok, mdl_cnt});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  {24'd0, udp_rx_data}, 32'd0);
        chk({tag, "_valid"}, {31'd0, udp_rx_valid}, 32'd0);
        chk({tag, "_last"},  {31'd0, udp_rx_last}, 32'd0);
        chk({tag, "_ok"},    {31'd0, frame_ok}, 32'd0);
        chk({tag, "_drop"},  {31'd0, frame_drop}, 32'd0);
        chk({tag, "_cnt"},   {16'd0, pkt_count}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal frame, then a series of rejects and edge cases, each separated by a single idle cycle
        defaults(); build(); exp_beats(4, 1); exp_verdict(1); send(fb.size(), -1);
        defaults(); f_port = 16'd5001; build(); exp_verdict(0); send(fb.size(), -1);
        defaults(); f_fcs_bad = 1'b1; build(); exp_beats(4, 1);
`ifdef UDP_RX_FCS_CHECK_EN
        exp_verdict(0);
`else
        exp_verdict(1);
`endif
        send(fb.size(), -1);
        defaults(); build(); exp_beats(2, 0); exp_verdict(0); send(52, -1);
        defaults(); build(); exp_beats(4, 1); exp_verdict(1); send(fb.size(), -1);
        defaults(); pl.delete(); f_len = 16'd8; f_pad = 18; build(); exp_verdict(1); send(fb.size(), -1);
        defaults(); f_mac = 48'hFFFFFFFFFFFF; pl.delete(); pl.push_back(8'h5A); f_len = 16'd9; f_pad = 17;
        build(); exp_beats(1, 1); exp_verdict(1); send(fb.size(), -1);
        defaults(); f_mac = 48'h000A35000002; build(); exp_verdict(0); send(fb.size(), -1);
        defaults(); f_etype = 16'h0806; build(); exp_verdict(0); send(fb.size(), -1);
        defaults(); f_proto = 8'h06; build(); exp_verdict(0); send(fb.size(), -1);
        defaults(); f_ip = 32'hC0A8010B; build(); exp_verdict(0); send(fb.size(), -1);
        defaults(); f_len = 16'd7; build(); exp_verdict(0); send(fb.size(), -1);
        defaults(); build(); exp_beats(2, 0); exp_verdict(0); send(fb.size(), 52);

        // Counter wrap from a preloaded 0xFFFF
        repeat (2) @(negedge clk);
        force dut.pkt_count = 16'hFFFF;
        #2;
        release dut.pkt_count;
        chk("preload", {16'd0, pkt_count}, 32'h0000FFFF);
        mdl_cnt = 16'hFFFF;
        defaults(); build(); exp_beats(4, 1); exp_verdict(1); send(fb.size(), -1);

        // Reset in the middle of the payload; the remainder of that frame must be ignored
        defaults(); build(); exp_beats(2, 0);
        for (int i = 0; i < 52; i++) drive_byte(fb[i], 1'b0);
        @(negedge clk);
        rstn = 1'b0; rx_data = fb[52];
        @(negedge clk);
        chk_all_zero("midreset");
        mdl_cnt = 16'd0;
        rstn = 1'b1; rx_data = fb[53];
        for (int i = 54; i < fb.size(); i++) drive_byte(fb[i], 1'b0);
        @(negedge clk);
        rx_valid = 1'b0; rx_data = 8'h00;
        defaults(); build(); exp_beats(4, 1); exp_verdict(1); send(fb.size(), -1);

        repeat (10) @(negedge clk);
        chk("beats_pending", beat_q.size(), 32'd0);
        chk("verdicts_pending", verdict_q.size(), 32'd0);
        chk("final_cnt", {16'd0, pkt_count}, {16'd0, mdl_cnt});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
